fpga_b_i2c_frame_rx: RTL and testbench
======================================

// Module: fpga_b_i2c_frame_rx
// PURPOSE
//  Receive-side I2C target on FPGA B for the board-to-board link.
//  Answers at a fixed 7-bit address and accepts write transfers only.
//  Rebuilds each 13-byte write burst into one 104-bit frame and presents it
//  to FPGA-B logic with a one-cycle valid strobe.
//  Consumes the byte stream produced by the FPGA-A I2C transmit path.
// PARAMETERS
//  SLAVE_ADDR   7'd7   7-bit target address this block ACKs
//  FRAME_BYTES  13     data bytes per frame; FRAME_W = 8*FRAME_BYTES (104)
// PORTS
//  clk          in     1        system clock; must be >= 16x SCL frequency
//  rst          in     1        asynchronous, active-low reset
//  i2c_scl      in     1        I2C clock; no clock stretching
//  i2c_sda      inout  1        I2C data; open-drain: driven 1'b0 or 1'bz only
//  frame_out    out    FRAME_W  last complete frame; first byte in [FRAME_W-1 -: 8]
//  frame_valid  out    1        1-cycle pulse when frame_out updates
//  frame_err    out    1        1-cycle pulse on short, long or aborted frame
//  busy         out    1        high from address match until STOP or restart
// BEHAVIOUR
//  Reset (rst=0, async)
//   - frame_out=0; frame_valid=0; frame_err=0; busy=0; SDA released (z).
//   - State=IDLE; byte count=0; partial frame buffer cleared.
//   - Reset mid-transfer releases SDA immediately; no error pulse.
//  Input sampling and bus events
//   - SCL/SDA pass through 2-FF synchronisers.
//   - All edges are detected on the synchronised copies.
//   - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
//   - START and STOP have priority over the state machine in any state.
//  State machine
//   - IDLE: wait for START -> ADDR.
//   - ADDR: shift 8 bits, MSB first, on SCL rising edges.
//     - Address matches and R/W=0 -> ADDR_ACK; set busy.
//     - Otherwise -> IGNORE; SDA stays released (NACK).
//   - ADDR_ACK / DATA_ACK: drive SDA low from the SCL falling edge after bit 8
//     to the next SCL falling edge, then release.
//   - DATA: shift 8 bits into the buffer at position count.
//     - count < FRAME_BYTES -> increment count, DATA_ACK.
//     - count == FRAME_BYTES (overflow byte) -> NACK, mark overflow, IGNORE.
//   - IGNORE: hold SDA released until START or STOP.
//  STOP handling
//   - count == FRAME_BYTES, no overflow:
//     - frame_out <= buffer and frame_valid=1 in the cycle after STOP detection.
//   - 0 < count < FRAME_BYTES, or overflow:
//     - frame_err=1 in the cycle after STOP detection; frame_out unchanged.
//   - count == 0 (address-only write or NACKed address): no pulse.
//   - All cases: count=0, overflow cleared, busy=0, state=IDLE.
//  Repeated START
//   - Treated as STOP evaluation followed by START:
//     a partial frame gives frame_err and the buffer is discarded.
//   - Then ADDR.
//  Timing rules
//   - frame_valid and frame_err never assert in the same cycle.
//   - frame_out is stable between frame_valid pulses.
// CONFIGURATION
//  FPGA_B_I2C_GLITCH_FILTER_EN
//   - Defined: a 3-sample majority filter follows each synchroniser.
//     Pulses of 1 clk are rejected. Event latency +2 clk (STOP -> valid = 5 clk).
//   - Undefined: no filter. STOP -> frame_valid latency = 3 clk from the raw SDA edge.
// TESTING
//  1. Write to addr 7, bytes 0x01..0x0D, STOP
//     -> ACK on all 14 bytes; frame_out = 104'h0102030405060708090A0B0C0D;
//        frame_valid for 1 cycle.
//  2. Write to addr 0x08
//     -> SDA never driven; busy=0; no pulses; frame_out unchanged.
//  3. Addr 7 with R/W=1
//     -> NACK; IGNORE until STOP; no pulses.
//  4. Write 5 bytes then STOP
//     -> frame_err pulse; frame_out keeps the value from test 1.
//  5. Write 14 bytes
//     -> 14th data byte NACKed; frame_err at STOP; no frame_valid.
//  6. rst low after byte 6
//     -> SDA released immediately; all outputs 0.
//     Then a full 13-byte frame (0xA0..0xAC) -> frame_valid with the correct value.

Source files
------------

// File: rtl/fpga_b_i2c_frame_rx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fpga_b_i2c_frame_rx
//
// Purpose:
//   Receive-side I2C target on FPGA B for the board-to-board link. Answers at
//   a fixed 7-bit address and accepts write transfers only. Every burst of
//   FRAME_BYTES data bytes is reassembled into one FRAME_W-bit frame and
//   handed to FPGA-B logic with a one-cycle valid strobe. Short, long or
//   aborted bursts produce a one-cycle error strobe instead.
//
// Parameters:
//   SLAVE_ADDR   7-bit target address that is ACKed (default 7'd7)
//   FRAME_BYTES  data bytes per frame (default 13); FRAME_W = 8*FRAME_BYTES
//
// Ports:
//   clk          system clock, at least 16x the SCL frequency
//   rst          asynchronous active-low reset
//   i2c_scl      I2C clock input (no clock stretching)
//   i2c_sda      I2C data, open-drain: driven 1'b0 or released (1'bz)
//   frame_out    last complete frame, first byte in [FRAME_W-1 -: 8]
//   frame_valid  one-cycle pulse when frame_out updates
//   frame_err    one-cycle pulse on a short, long or aborted frame
//   busy         high from address match until STOP or repeated START
//
// Configuration:
//   FPGA_B_I2C_GLITCH_FILTER_EN  when defined, a 3-sample majority filter
//   follows each synchroniser, rejecting 1-clk pulses and adding 2 clk of
//   event latency (STOP -> frame_valid = 5 clk instead of 3 clk).
// ---------------------------------------------------------------------------
module fpga_b_i2c_frame_rx #(
  parameter logic [6:0] SLAVE_ADDR  = 7'd7,
  parameter int         FRAME_BYTES = 13,
  localparam int        FRAME_W     = 8 * FRAME_BYTES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i2c_scl,
  inout  wire                i2c_sda,
  output logic [FRAME_W-1:0] frame_out,
  output logic               frame_valid,
  output logic               frame_err,
  output logic               busy
);

  localparam int               CNT_W    = $clog2(FRAME_BYTES + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } state_t;

  // Two-flop synchronisers. They reset to the idle-bus level (both lines
  // high) so that leaving reset never looks like a START or STOP.
  logic sclMeta_q, sclSync_q;
  logic sdaMeta_q, sdaSync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclMeta_q <= 1'b1;
      sclSync_q <= 1'b1;
      sdaMeta_q <= 1'b1;
      sdaSync_q <= 1'b1;
    end else begin
      sclMeta_q <= i2c_scl;
      sclSync_q <= sclMeta_q;
      sdaMeta_q <= i2c_sda;
      sdaSync_q <= sdaMeta_q;
    end
  end

  logic sclFilt;
  logic sdaFilt;

`ifdef FPGA_B_I2C_GLITCH_FILTER_EN
  // Majority of the current synchronised sample and the two before it,
  // registered. A one-clock pulse never wins the vote.
  logic [1:0] sclHist_q, sdaHist_q;
  logic       sclMaj_q, sdaMaj_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclHist_q <= 2'b11;
      sdaHist_q <= 2'b11;
      sclMaj_q  <= 1'b1;
      sdaMaj_q  <= 1'b1;
    end else begin
      sclHist_q <= {sclHist_q[0], sclSync_q};
      sdaHist_q <= {sdaHist_q[0], sdaSync_q};
      sclMaj_q  <= (sclSync_q & sclHist_q[0]) | (sclSync_q & sclHist_q[1]) |
                   (sclHist_q[0] & sclHist_q[1]);
      sdaMaj_q  <= (sdaSync_q & sdaHist_q[0]) | (sdaSync_q & sdaHist_q[1]) |
                   (sdaHist_q[0] & sdaHist_q[1]);
    end
  end

  assign sclFilt = sclMaj_q;
  assign sdaFilt = sdaMaj_q;
`else
  assign sclFilt = sclSync_q;
  assign sdaFilt = sdaSync_q;
`endif

  // Previous-sample registers for edge and bus-condition detection.
  logic sclPrev_q, sdaPrev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclPrev_q <= 1'b1;
      sdaPrev_q <= 1'b1;
    end else begin
      sclPrev_q <= sclFilt;
      sdaPrev_q <= sdaFilt;
    end
  end

  logic sclRise, sclFall, startDet, stopDet;

  assign sclRise  = sclFilt & ~sclPrev_q;
  assign sclFall  = ~sclFilt & sclPrev_q;
  // SDA may only move while SCL is low, so an SDA edge with SCL held high
  // across both samples is a bus condition rather than data.
  assign startDet = sclFilt & sclPrev_q & sdaPrev_q & ~sdaFilt;
  assign stopDet  = sclFilt & sclPrev_q & ~sdaPrev_q & sdaFilt;

  // Receiver state.
  state_t             state_q, state_d;
  logic [2:0]         bitCnt_q, bitCnt_d;
  logic [6:0]         shift_q, shift_d;
  logic [CNT_W-1:0]   byteCnt_q, byteCnt_d;
  logic               overflow_q, overflow_d;
  logic               busy_q, busy_d;
  logic               sdaLow_q, sdaLow_d;
  logic [FRAME_W-1:0] frameBuf_q, frameBuf_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [7:0]         rxByte;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      byteCnt_q  <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      sdaLow_q   <= 1'b0;
      frameBuf_q <= '0;
      frame_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      byteCnt_q  <= byteCnt_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      sdaLow_q   <= sdaLow_d;
      frameBuf_q <= frameBuf_d;
      frame_q    <= frame_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    byteCnt_d  = byteCnt_q;
    overflow_d = overflow_q;
    busy_d     = busy_q;
    sdaLow_d   = sdaLow_q;
    frameBuf_d = frameBuf_q;
    frame_d    = frame_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    // Byte as it stands once the bit currently on SDA is shifted in.
    rxByte     = {shift_q, sdaFilt};

    if (startDet || stopDet) begin
      // A repeated START closes the previous transfer exactly like a STOP,
      // so both share the frame evaluation. Overflow always implies a full
      // count, so it must be tested before the "complete frame" case.
      if (byteCnt_q == FULL_CNT && !overflow_q) begin
        valid_d = 1'b1;
        frame_d = frameBuf_q;
      end else if (byteCnt_q != '0 || overflow_q) begin
        err_d = 1'b1;
      end
      byteCnt_d  = '0;
      overflow_d = 1'b0;
      busy_d     = 1'b0;
      sdaLow_d   = 1'b0;
      bitCnt_d   = '0;
      frameBuf_d = '0;
      state_d    = startDet ? ADDR : IDLE;
    end else begin
      case (state_q)
        ADDR: begin
          if (sclRise) begin
            shift_d  = rxByte[6:0];
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              if (rxByte[7:1] == SLAVE_ADDR && !rxByte[0]) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end

        // The ACK slot spans two SCL falling edges: the first one (end of
        // bit 8) pulls SDA low, the second one (end of the ACK clock)
        // releases it and hands over to the next data byte.
        ADDR_ACK, DATA_ACK: begin
          if (sclFall) begin
            if (!sdaLow_q) begin
              sdaLow_d = 1'b1;
            end else begin
              sdaLow_d = 1'b0;
              state_d  = DATA;
            end
          end
        end

        DATA: begin
          if (sclRise) begin
            shift_d  = rxByte[6:0];
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              if (byteCnt_q < FULL_CNT) begin
                for (int i = 0; i < FRAME_BYTES; i++) begin
                  if (byteCnt_q == CNT_W'(i)) begin
                    frameBuf_d[FRAME_W-1-8*i -: 8] = rxByte;
                  end
                end
                byteCnt_d = byteCnt_q + 1'b1;
                state_d   = DATA_ACK;
              end else begin
                // One byte too many: leave SDA released (NACK) and wait for
                // the STOP that will report the error.
                overflow_d = 1'b1;
                state_d    = IGNORE;
              end
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign i2c_sda     = sdaLow_q ? 1'b0 : 1'bz;
  assign frame_out   = frame_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_fpga_b_i2c_frame_rx.sv
`timescale 1ns/1ps
// Self-checking bench for fpga_b_i2c_frame_rx. A bit-banged I2C controller
// drives the bus; expected ACKs, strobes and frame contents come from a
// transfer-level model of the target's rules.
module tb_fpga_b_i2c_frame_rx;

  localparam int         FRAME_BYTES = 13;
  localparam int         FRAME_W     = 8 * FRAME_BYTES;
  localparam logic [6:0] SLAVE_ADDR  = 7'd7;
  localparam int         T_Q         = 50;
`ifdef FPGA_B_I2C_GLITCH_FILTER_EN
  localparam int         LAT         = 5;
`else
  localparam int         LAT         = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sclDrv = 1'b1;
  logic sdaLow = 1'b0;
  wire  sda;
  assign sda = sdaLow ? 1'b0 : 1'bz;
  pullup (sda);

  logic [FRAME_W-1:0] frame_out;
  logic               frame_valid;
  logic               frame_err;
  logic               busy;

  fpga_b_i2c_frame_rx #(
    .SLAVE_ADDR (SLAVE_ADDR),
    .FRAME_BYTES(FRAME_BYTES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i2c_scl    (sclDrv),
    .i2c_sda    (sda),
    .frame_out  (frame_out),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int assertCnt = 0;
  int failCnt   = 0;

  // Bus monitor, sampled on the falling clock edge.
  int validPulses = 0;
  int errPulses   = 0;
  int slaveDrive  = 0;
  int busyCycles  = 0;
  int bothTotal   = 0;
  int unstableCnt = 0;
  int cyc         = 0;
  int edgeCyc     = 0;
  int pulseCyc    = -1;
  logic [FRAME_W-1:0] prevOut = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      prevOut = frame_out;
    end else begin
      if (frame_valid) validPulses++;
      if (frame_err) errPulses++;
      if (frame_valid && frame_err) bothTotal++;
      if (busy) busyCycles++;
      if ((frame_valid || frame_err) && pulseCyc < 0) pulseCyc = cyc - edgeCyc;
      if (frame_out !== prevOut && !frame_valid) unstableCnt++;
      prevOut = frame_out;
    end
    if (!sdaLow && sda === 1'b0) slaveDrive++;
  end

  // Transfer data and collected ACKs (index 0 is the address byte).
  logic [7:0]         txBytes [16];
  logic               ackGot  [17];
  logic [FRAME_W-1:0] lastFrame = '0;

  // ---------------- reference model ----------------
  function automatic logic model_ack(logic [6:0] a, logic rw, int idx);
    logic addrOk = (a == SLAVE_ADDR) && !rw;
    if (idx == 0) return addrOk;
    return addrOk && (idx <= FRAME_BYTES);
  endfunction

  // 0 = no strobe, 1 = frame_valid, 2 = frame_err
  function automatic int model_outcome(logic [6:0] a, logic rw, int n);
    if (a != SLAVE_ADDR || rw) return 0;
    if (n == 0) return 0;
    if (n == FRAME_BYTES) return 1;
    return 2;
  endfunction

  function automatic logic [FRAME_W-1:0] model_frame();
    logic [FRAME_W-1:0] r = '0;
    for (int i = 0; i < FRAME_BYTES; i++) r = {r[FRAME_W-9:0], txBytes[i]};
    return r;
  endfunction

  // ---------------- bus controller ----------------
  task automatic bus_start();
    sdaLow = 1'b0; #T_Q;
    sclDrv = 1'b1; #T_Q;
    sdaLow = 1'b1; #T_Q;
    sclDrv = 1'b0; #T_Q;
  endtask

  task automatic bus_bit(input logic b, output logic rd);
    sdaLow = ~b;   #T_Q;
    sclDrv = 1'b1; #T_Q;
    rd = sda;      #T_Q;
    sclDrv = 1'b0; #T_Q;
  endtask

  task automatic bus_byte(input logic [7:0] b, output logic ack);
    logic d;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], d);
    bus_bit(1'b1, d);
    ack = (d === 1'b0);
  endtask

  task automatic bus_stop();
    sdaLow = 1'b1; #T_Q;
    sclDrv = 1'b1; #T_Q;
    edgeCyc  = cyc;
    pulseCyc = -1;
    sdaLow = 1'b0; #T_Q;
    #T_Q;
  endtask

  task automatic clear_monitor();
    validPulses = 0;
    errPulses   = 0;
    slaveDrive  = 0;
    busyCycles  = 0;
  endtask

  task automatic run_write(input logic [6:0] a, input logic rw, input int n, input bit doStop);
    clear_monitor();
    bus_start();
    bus_byte({a, rw}, ackGot[0]);
    for (int i = 0; i < n; i++) bus_byte(txBytes[i], ackGot[i+1]);
    if (doStop) begin
      bus_stop();
      repeat (10) @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    assertCnt++;
    if (frame_out !== '0) begin failCnt++; $display("[TB] FAIL reset_frame: got %0h, expected 0", frame_out); end
    assertCnt++;
    if ({frame_valid, frame_err, busy} !== 3'b000) begin
      failCnt++; $display("[TB] FAIL reset_flags: got %b, expected 000", {frame_valid, frame_err, busy});
    end
    assertCnt++;
    if (sda !== 1'b1) begin failCnt++; $display("[TB] FAIL reset_sda: got %b, expected 1", sda); end
    rst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_full_frame();
    logic [FRAME_W-1:0] expFrame = 104'h0102030405060708090A0B0C0D;
    for (int i = 0; i < FRAME_BYTES; i++) txBytes[i] = 8'(i + 1);
    run_write(SLAVE_ADDR, 1'b0, FRAME_BYTES, 1'b1);
    for (int i = 0; i <= FRAME_BYTES; i++) begin
      assertCnt++;
      if (ackGot[i] !== 1'b1) begin failCnt++; $display("[TB] FAIL full_ack[%0d]: got %b, expected 1", i, ackGot[i]); end
    end
    assertCnt++;
    if (validPulses != 1 || errPulses != 0) begin
      failCnt++; $display("[TB] FAIL full_pulses: got valid=%0d err=%0d, expected valid=1 err=0", validPulses, errPulses);
    end
    assertCnt++;
    if (frame_out !== expFrame) begin failCnt++; $display("[TB] FAIL full_frame: got %0h, expected %0h", frame_out, expFrame); end
    assertCnt++;
    if (pulseCyc != LAT) begin failCnt++; $display("[TB] FAIL full_latency: got %0d, expected %0d", pulseCyc, LAT); end
    assertCnt++;
    if (busyCycles == 0 || busy !== 1'b0) begin
      failCnt++; $display("[TB] FAIL full_busy: got cycles=%0d final=%b, expected cycles>0 final=0", busyCycles, busy);
    end
    lastFrame = expFrame;
  endtask

  task automatic test_wrong_addr();
    for (int i = 0; i < 3; i++) txBytes[i] = 8'($urandom);
    run_write(7'h08, 1'b0, 3, 1'b1);
    assertCnt++;
    if (slaveDrive != 0) begin failCnt++; $display("[TB] FAIL waddr_sda: got %0d driven cycles, expected 0", slaveDrive); end
    assertCnt++;
    if (busyCycles != 0) begin failCnt++; $display("[TB] FAIL waddr_busy: got %0d, expected 0", busyCycles); end
    assertCnt++;
    if (validPulses + errPulses != 0) begin failCnt++; $display("[TB] FAIL waddr_pulses: got %0d, expected 0", validPulses + errPulses); end
    assertCnt++;
    if (frame_out !== lastFrame) begin failCnt++; $display("[TB] FAIL waddr_frame: got %0h, expected %0h", frame_out, lastFrame); end
  endtask

  task automatic test_read_nack();
    for (int i = 0; i < 2; i++) txBytes[i] = 8'($urandom);
    run_write(SLAVE_ADDR, 1'b1, 2, 1'b1);
    assertCnt++;
    if (ackGot[0] !== 1'b0) begin failCnt++; $display("[TB] FAIL read_ack: got %b, expected 0", ackGot[0]); end
    assertCnt++;
    if (slaveDrive != 0 || busyCycles != 0) begin
      failCnt++; $display("[TB] FAIL read_ignore: got drive=%0d busy=%0d, expected 0 0", slaveDrive, busyCycles);
    end
    assertCnt++;
    if (validPulses + errPulses != 0) begin failCnt++; $display("[TB] FAIL read_pulses: got %0d, expected 0", validPulses + errPulses); end
  endtask

  task automatic test_short_frame();
    for (int i = 0; i < 5; i++) txBytes[i] = 8'($urandom);
    run_write(SLAVE_ADDR, 1'b0, 5, 1'b1);
    for (int i = 0; i <= 5; i++) begin
      assertCnt++;
      if (ackGot[i] !== 1'b1) begin failCnt++; $display("[TB] FAIL short_ack[%0d]: got %b, expected 1", i, ackGot[i]); end
    end
    assertCnt++;
    if (errPulses != 1 || validPulses != 0) begin
      failCnt++; $display("[TB] FAIL short_pulses: got valid=%0d err=%0d, expected valid=0 err=1", validPulses, errPulses);
    end
    assertCnt++;
    if (pulseCyc != LAT) begin failCnt++; $display("[TB] FAIL short_latency: got %0d, expected %0d", pulseCyc, LAT); end
    assertCnt++;
    if (frame_out !== lastFrame) begin failCnt++; $display("[TB] FAIL short_frame: got %0h, expected %0h", frame_out, lastFrame); end
  endtask

  task automatic test_long_frame();
    for (int i = 0; i < FRAME_BYTES + 1; i++) txBytes[i] = 8'($urandom);
    run_write(SLAVE_ADDR, 1'b0, FRAME_BYTES + 1, 1'b1);
    for (int i = 0; i <= FRAME_BYTES + 1; i++) begin
      assertCnt++;
      if (ackGot[i] !== model_ack(SLAVE_ADDR, 1'b0, i)) begin
        failCnt++; $display("[TB] FAIL long_ack[%0d]: got %b, expected %b", i, ackGot[i], model_ack(SLAVE_ADDR, 1'b0, i));
      end
    end
    assertCnt++;
    if (errPulses != 1 || validPulses != 0) begin
      failCnt++; $display("[TB] FAIL long_pulses: got valid=%0d err=%0d, expected valid=0 err=1", validPulses, errPulses);
    end
    assertCnt++;
    if (frame_out !== lastFrame) begin failCnt++; $display("[TB] FAIL long_frame: got %0h, expected %0h", frame_out, lastFrame); end
  endtask

  task automatic test_reset_mid();
    logic d;
    clear_monitor();
    for (int i = 0; i < 6; i++) txBytes[i] = 8'($urandom);
    bus_start();
    bus_byte({SLAVE_ADDR, 1'b0}, ackGot[0]);
    for (int i = 0; i < 5; i++) bus_byte(txBytes[i], ackGot[i+1]);
    for (int i = 7; i >= 0; i--) bus_bit(txBytes[5][i], d);
    sdaLow = 1'b0;
    assertCnt++;
    if (sda !== 1'b0) begin failCnt++; $display("[TB] FAIL rstmid_ack_driven: got %b, expected 0", sda); end
    rst = 1'b0;
    #1;
    assertCnt++;
    if (sda !== 1'b1) begin failCnt++; $display("[TB] FAIL rstmid_sda: got %b, expected 1", sda); end
    assertCnt++;
    if (frame_out !== '0 || {frame_valid, frame_err, busy} !== 3'b000) begin
      failCnt++; $display("[TB] FAIL rstmid_outputs: got frame=%0h flags=%b, expected 0 000", frame_out, {frame_valid, frame_err, busy});
    end
    #(T_Q - 1);
    sclDrv = 1'b1; #T_Q;
    rst = 1'b1;    #T_Q;
    assertCnt++;
    if (errPulses != 0) begin failCnt++; $display("[TB] FAIL rstmid_noerr: got %0d, expected 0", errPulses); end
    for (int i = 0; i < FRAME_BYTES; i++) txBytes[i] = 8'(8'hA0 + i);
    run_write(SLAVE_ADDR, 1'b0, FRAME_BYTES, 1'b1);
    assertCnt++;
    if (validPulses != 1 || errPulses != 0) begin
      failCnt++; $display("[TB] FAIL rstmid_pulses: got valid=%0d err=%0d, expected valid=1 err=0", validPulses, errPulses);
    end
    assertCnt++;
    if (frame_out !== 104'hA0A1A2A3A4A5A6A7A8A9AAABAC) begin
      failCnt++; $display("[TB] FAIL rstmid_frame: got %0h, expected a0a1a2a3a4a5a6a7a8a9aaabac", frame_out);
    end
    lastFrame = 104'hA0A1A2A3A4A5A6A7A8A9AAABAC;
  endtask

  task automatic test_repeated_start();
    for (int i = 0; i < 5; i++) txBytes[i] = 8'($urandom);
    run_write(SLAVE_ADDR, 1'b0, 5, 1'b0);
    for (int i = 0; i < FRAME_BYTES; i++) txBytes[i] = 8'($urandom);
    run_write(SLAVE_ADDR, 1'b0, FRAME_BYTES, 1'b1);
    assertCnt++;
    if (errPulses != 1 || validPulses != 1) begin
      failCnt++; $display("[TB] FAIL restart_pulses: got valid=%0d err=%0d, expected valid=1 err=1", validPulses, errPulses);
    end
    assertCnt++;
    if (frame_out !== model_frame()) begin failCnt++; $display("[TB] FAIL restart_frame: got %0h, expected %0h", frame_out, model_frame()); end
    lastFrame = model_frame();
  endtask

  task automatic test_random();
    logic [6:0] a;
    logic       rw;
    int         n;
    int         outc;
    for (int t = 0; t < 6; t++) begin
      a  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SLAVE_ADDR;
      rw = ($urandom_range(0, 3) == 0);
      n  = ($urandom_range(0, 1) == 1) ? FRAME_BYTES : $urandom_range(0, 15);
      for (int i = 0; i < n; i++) txBytes[i] = 8'($urandom);
      run_write(a, rw, n, 1'b1);
      outc = model_outcome(a, rw, n);
      for (int i = 0; i <= n; i++) begin
        assertCnt++;
        if (ackGot[i] !== model_ack(a, rw, i)) begin
          failCnt++; $display("[TB] FAIL rand%0d_ack[%0d]: got %b, expected %b", t, i, ackGot[i], model_ack(a, rw, i));
        end
      end
      assertCnt++;
      if (validPulses != int'(outc == 1) || errPulses != int'(outc == 2)) begin
        failCnt++; $display("[TB] FAIL rand%0d_pulses: got valid=%0d err=%0d, expected valid=%0d err=%0d",
                            t, validPulses, errPulses, int'(outc == 1), int'(outc == 2));
      end
      if (outc == 1) lastFrame = model_frame();
      assertCnt++;
      if (frame_out !== lastFrame) begin failCnt++; $display("[TB] FAIL rand%0d_frame: got %0h, expected %0h", t, frame_out, lastFrame); end
    end
  endtask

  task automatic test_timing_rules();
    assertCnt++;
    if (bothTotal != 0) begin failCnt++; $display("[TB] FAIL both_strobes: got %0d, expected 0", bothTotal); end
    assertCnt++;
    if (unstableCnt != 0) begin failCnt++; $display("[TB] FAIL frame_stable: got %0d changes, expected 0", unstableCnt); end
  endtask

  initial begin
    #3_000_000;
    failCnt++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_full_frame();
    test_wrong_addr();
    test_read_nack();
    test_short_frame();
    test_long_frame();
    test_reset_mid();
    test_repeated_start();
    test_random();
    test_timing_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
